// File: rtl/sr_seq_ctrl.sv
// sr_seq_ctrl: command sequencer for a W-bit serial-in/parallel-load shift register.
//
// Accepts one command at a time and drives the attached register to either
// parallel-load a word and shift it back out (LOAD_OUT, op=0), or serially
// shift a word in (SHIFT_IN, op=1). The resulting word and a mismatch flag are
// returned over a response handshake.
//
// Attached register behaviour: load=1 gives q<=d, otherwise q<={data, q[0:W-2]};
// q[W-1] is the serial output. The register itself has no reset.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  controller can accept a command (IDLE only)
//   cmd_op     0 = LOAD_OUT, 1 = SHIFT_IN
//   cmd_word   command word
//   rsp_valid  response present (DONE only)
//   rsp_ready  consumer accepts response
//   rsp_word   result word (0 outside DONE)
//   rsp_err    result differs from command word (0 outside DONE)
//   busy       high in any state except IDLE
//   sr_load    shift register load
//   sr_d       shift register parallel input
//   sr_data    shift register serial input
//   sr_q       shift register output
module sr_seq_ctrl #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic [0:W-1] cmd_word,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [0:W-1] rsp_word,
  output logic         rsp_err,
  output logic         busy,
  output logic         sr_load,
  output logic [0:W-1] sr_d,
  output logic         sr_data,
  input  logic [0:W-1] sr_q
);

  localparam int unsigned CntW = $clog2(W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic            op_q, op_d;
  logic [0:W-1]    word_q, word_d;
  logic [0:W-1]    cap_q, cap_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 1'b0;
      word_q  <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      word_q  <= word_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
    end
  end

  // All sr_* and cmd_ready decode from registered state only; cmd_* never
  // reaches the shift register combinationally.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    word_d    = word_q;
    cap_d     = cap_q;
    cnt_d     = cnt_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_word  = '0;
    rsp_err   = 1'b0;
    busy      = 1'b1;
    sr_load   = 1'b0;
    sr_d      = '0;
    sr_data   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          word_d  = cmd_word;
          op_d    = cmd_op;
          cnt_d   = '0;
          cap_d   = '0;
          state_d = cmd_op ? StShift : StLoad;
        end
      end

      StLoad: begin
        sr_load = 1'b1;
        sr_d    = word_q;
        state_d = StShift;
      end

      StShift: begin
        if (!op_q) begin
          // Capture the serial output as it leaves; after W edges cap holds
          // the loaded word in its original bit order.
          cap_d = {sr_q[W-1], cap_q[0:W-2]};
        end else begin
          // Feed word_q[W-1-cnt]: the highest index goes in first so it ends
          // up at q[W-1] after W shifts.
          for (int unsigned i = 0; i < W; i++) begin
            if (cnt_q == CntW'(W - 1 - i)) begin
              sr_data = word_q[i];
            end
          end
        end
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        rsp_valid = 1'b1;
        rsp_word  = op_q ? sr_q : cap_q;
        rsp_err   = (rsp_word != word_q);
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_sr_seq_ctrl.sv
// tb_sr_seq_ctrl: self-checking bench for sr_seq_ctrl with a behavioural model
// of the attached 3-bit shift register (with an optional stuck-at-0 on q[2]).
module tb_sr_seq_ctrl;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_op;
  logic [0:W-1] cmd_word;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [0:W-1] rsp_word;
  logic         rsp_err;
  logic         busy;
  logic         sr_load;
  logic [0:W-1] sr_d;
  logic         sr_data;
  logic [0:W-1] sr_q;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;

  sr_seq_ctrl #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_word  (cmd_word),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_word  (rsp_word),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .sr_load   (sr_load),
    .sr_d      (sr_d),
    .sr_data   (sr_data),
    .sr_q      (sr_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached shift register model: no reset, q[W-1] is serial out.
  logic [0:W-1] sr_reg = '0;
  logic         fault;
  always_ff @(posedge clk) begin
    if (sr_load) sr_reg <= sr_d;
    else         sr_reg <= {sr_data, sr_reg[0:W-2]};
  end
  assign sr_q = {sr_reg[0], sr_reg[1], sr_reg[2] & ~fault};

  // Handshake counters, sampled mid-cycle after inputs have settled.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (cmd_valid && cmd_ready) acc_cnt++;
      if (rsp_valid && rsp_ready) rsp_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Per-command trace of the register drive, one entry per cycle until rsp_valid.
  logic         tr_load [16];
  logic [0:W-1] tr_d    [16];
  logic         tr_data [16];
  int           tr_n;
  logic [0:W-1] done_reg;

  task automatic run_cmd(input logic op, input logic [0:W-1] word,
                         output logic [0:W-1] w, output logic e, output int lat);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_word  = word;
    rsp_ready = 1'b0;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat  = 0;
    tr_n = 0;
    while (!rsp_valid && lat < 20) begin
      if (tr_n < 16) begin
        tr_load[tr_n] = sr_load;
        tr_d[tr_n]    = sr_d;
        tr_data[tr_n] = sr_data;
        tr_n++;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    w        = rsp_word;
    e        = rsp_err;
    done_reg = sr_reg;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("idle_busy", busy, 0);
  endtask

  typedef struct {
    logic         op;
    logic [0:W-1] word;
    logic         fault;
    logic [0:W-1] exp_word;
    logic         exp_err;
    int           exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [0:W-1] w, w0, exp_seq, got_seq;
    logic         e, e0;
    int           lat, nload, n, acc0, r0, sent, got, cyc, seen;
    logic [0:W-1] expq [$];
    logic [0:W-1] ew;

    vecs[0] = '{1'b0, 3'b101, 1'b0, 3'b101, 1'b0, 4};
    vecs[1] = '{1'b1, 3'b110, 1'b0, 3'b110, 1'b0, 3};
    vecs[2] = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b1, 4};
    vecs[3] = '{1'b1, 3'b011, 1'b1, 3'b010, 1'b1, 3};
    vecs[4] = '{1'b0, 3'b010, 1'b0, 3'b010, 1'b0, 4};
    vecs[5] = '{1'b1, 3'b001, 1'b0, 3'b001, 1'b0, 3};

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_word  = '0;
    rsp_ready = 1'b0;
    fault     = 1'b0;

    // Reset state.
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_word", rsp_word, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_sr_load", sr_load, 0);
    check("rst_sr_d", sr_d, 0);
    check("rst_sr_data", sr_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed command table.
    for (int i = 0; i < 6; i++) begin
      fault = vecs[i].fault;
      run_cmd(vecs[i].op, vecs[i].word, w, e, lat);
      check($sformatf("vec%0d_rsp_word", i), w, vecs[i].exp_word);
      check($sformatf("vec%0d_rsp_err", i), e, vecs[i].exp_err);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      nload = 0;
      for (int k = 0; k < tr_n; k++) if (tr_load[k]) nload++;
      check($sformatf("vec%0d_load_cycles", i), nload, vecs[i].op ? 0 : 1);
      if (!vecs[i].op) check($sformatf("vec%0d_load_d", i), tr_d[0], vecs[i].word);
      got_seq = 'x;
      if (tr_n >= 3) for (int k = 0; k < 3; k++) got_seq[k] = tr_data[tr_n - 3 + k];
      exp_seq = vecs[i].op ? {vecs[i].word[2], vecs[i].word[1], vecs[i].word[0]} : 3'b000;
      check($sformatf("vec%0d_data_seq", i), got_seq, exp_seq);
      check($sformatf("vec%0d_sr_final", i), done_reg, vecs[i].op ? vecs[i].word : 3'b000);
    end
    fault = 1'b0;

    // Reset during the SHIFT phase of a LOAD_OUT.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_word  = 3'b101;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_sr_load", sr_load, 0);
    check("mid_rst_sr_data", sr_data, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    check("post_rst_no_rsp", seen, 0);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Backpressure in DONE with a competing command held valid.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_word  = 3'b011;
    rsp_ready = 1'b0;
    acc0 = acc_cnt;
    check("bp_ready", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_op   = 1'b1;
    cmd_word = 3'b100;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("bp_rsp_valid", rsp_valid, 1);
    w0 = rsp_word;
    e0 = rsp_err;
    check("bp_word", w0, 3'b011);
    check("bp_err", e0, 0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp%0d_rsp_valid", k), rsp_valid, 1);
      check($sformatf("bp%0d_rsp_word", k), rsp_word, w0);
      check($sformatf("bp%0d_rsp_err", k), rsp_err, e0);
      check($sformatf("bp%0d_cmd_ready", k), cmd_ready, 0);
      check($sformatf("bp%0d_sr_load", k), sr_load, 0);
      check($sformatf("bp%0d_sr_data", k), sr_data, 0);
    end
    check("bp_no_second_accept", acc_cnt, acc0 + 1);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_after_hs_rsp_valid", rsp_valid, 0);
    check("bp_after_hs_cmd_ready", cmd_ready, 1);
    check("bp_after_hs_accepts", acc_cnt, acc0 + 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_next_busy", busy, 1);
    check("bp_next_accepts", acc_cnt, acc0 + 2);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("bp_next_word", rsp_word, 3'b100);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Back-to-back sweep: every word as LOAD_OUT then SHIFT_IN.
    r0   = rsp_cnt;
    sent = 0;
    got  = 0;
    cyc  = 0;
    rsp_ready = 1'b1;
    while (got < 16 && cyc < 400) begin
      if (sent < 16) begin
        cmd_valid = 1'b1;
        cmd_op    = sent[0];
        cmd_word  = 3'(sent >> 1);
      end else begin
        cmd_valid = 1'b0;
      end
      if (rsp_valid) begin
        ew = (expq.size() > 0) ? expq.pop_front() : 3'bxxx;
        check($sformatf("sweep%0d_word", got), rsp_word, ew);
        check($sformatf("sweep%0d_err", got), rsp_err, 0);
        got++;
      end
      if (cmd_valid && cmd_ready) begin
        expq.push_back(cmd_word);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk);
    rsp_ready = 1'b0;
    check("sweep_responses", got, 16);
    check("sweep_handshakes", rsp_cnt - r0, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
